// File: rtl/regbank_pkg.sv
// Shared constants and the read-port FSM encoding for the 32 x 32-bit MIPS32 register bank.
package regbank_pkg;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    localparam logic [AW-1:0] ZERO_REG = '0;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } port_state_e;

endpackage

// File: rtl/reg_read_port.sv
// One read port: req/valid/ack FSM plus a snapshot data register.
// The port forwards a same-cycle write to its own address.
module reg_read_port
    import regbank_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             req,
    input  logic [AW-1:0]    addr,
    input  logic             ack,
    output logic             rdy,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] word,
    input  logic             wr_en,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] din
);

    port_state_e state, next_state;
    logic             capture;
    logic [WIDTH-1:0] capture_word;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req) next_state = HOLD;
            HOLD:    if (ack) next_state = req ? HOLD : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        valid = (state == HOLD);
        rdy   = ~valid | ack;
    end

    assign capture = req & rdy;

    always_comb begin
        capture_word = word;
        if (addr == ZERO_REG)
            capture_word = '0;
        else if (wr_en && (waddr == addr))
            capture_word = din;
    end

    // The snapshot only changes on an accepted request, never on later writes.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)          data <= '0;
        else if (capture) data <= capture_word;
    end

endmodule

// File: rtl/regbank_read_ctrl.sv
// Register bank storage with gated write decode and two independent snapshot read ports.
module regbank_read_ctrl
    import regbank_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             ld,
    input  logic             strobe,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] din,
    input  logic             a_req,
    input  logic [AW-1:0]    a_addr,
    output logic             a_rdy,
    output logic             a_valid,
    output logic [WIDTH-1:0] a_data,
    input  logic             a_ack,
    input  logic             b_req,
    input  logic [AW-1:0]    b_addr,
    output logic             b_rdy,
    output logic             b_valid,
    output logic [WIDTH-1:0] b_data,
    input  logic             b_ack
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic             wr_en;

    assign wr_en = ld & strobe & (waddr != ZERO_REG);

    // NOTE: the bank must read back zero after clr, so the storage array is reset too.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[waddr] <= din;
        end
    end

    reg_read_port u_port_a (
        .clk   (clk),
        .clr   (clr),
        .req   (a_req),
        .addr  (a_addr),
        .ack   (a_ack),
        .rdy   (a_rdy),
        .valid (a_valid),
        .data  (a_data),
        .word  (regs[a_addr]),
        .wr_en (wr_en),
        .waddr (waddr),
        .din   (din)
    );

    reg_read_port u_port_b (
        .clk   (clk),
        .clr   (clr),
        .req   (b_req),
        .addr  (b_addr),
        .ack   (b_ack),
        .rdy   (b_rdy),
        .valid (b_valid),
        .data  (b_data),
        .word  (regs[b_addr]),
        .wr_en (wr_en),
        .waddr (waddr),
        .din   (din)
    );

endmodule

// File: tb/tb_regbank_read_ctrl.sv
// Self-checking bench for regbank_read_ctrl: directed scenarios plus randomized traffic
// checked against an array-based model of the register bank and both read ports.
module tb_regbank_read_ctrl;

    logic        clk = 1'b0;
    logic        clr, ld, strobe;
    logic [4:0]  waddr;
    logic [31:0] din;
    logic        a_req, a_ack, a_rdy, a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        b_req, b_ack, b_rdy, b_valid;
    logic [4:0]  b_addr;
    logic [31:0] b_data;

    int passed = 0;
    int total  = 0;

    logic [31:0] model [32];

    always #5 clk = ~clk;

    regbank_read_ctrl dut (
        .clk(clk), .clr(clr), .ld(ld), .strobe(strobe), .waddr(waddr), .din(din),
        .a_req(a_req), .a_addr(a_addr), .a_rdy(a_rdy), .a_valid(a_valid),
        .a_data(a_data), .a_ack(a_ack),
        .b_req(b_req), .b_addr(b_addr), .b_rdy(b_rdy), .b_valid(b_valid),
        .b_data(b_data), .b_ack(b_ack)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = '0;
    endtask

    task automatic write_reg(input logic [4:0] idx, input logic [31:0] val,
                             input logic l, input logic s);
        ld = l; strobe = s; waddr = idx; din = val;
        tick();
        if (l && s && idx != 0) model[idx] = val;
        ld = 0; strobe = 0;
    endtask

    // Read one index on both ports, hold without ack, then release and confirm retention.
    task automatic read_both(input string name, input logic [4:0] ia, input logic [31:0] ea,
                             input logic [4:0] ib, input logic [31:0] eb);
        a_req = 1; a_addr = ia; a_ack = 0;
        b_req = 1; b_addr = ib; b_ack = 0;
        tick();
        a_req = 0; b_req = 0;
        total++;
        if (a_valid !== 1'b1 || a_data !== ea)
            $display("FAIL %s port A: valid=%b data=%h, want valid=1 data=%h", name, a_valid, a_data, ea);
        else passed++;
        total++;
        if (b_valid !== 1'b1 || b_data !== eb)
            $display("FAIL %s port B: valid=%b data=%h, want valid=1 data=%h", name, b_valid, b_data, eb);
        else passed++;
        a_ack = 1; b_ack = 1;
        tick();
        a_ack = 0; b_ack = 0;
        total++;
        if (a_valid !== 1'b0 || a_data !== ea || b_valid !== 1'b0 || b_data !== eb)
            $display("FAIL %s release: a_valid=%b a_data=%h b_valid=%b b_data=%h, want 0/%h 0/%h",
                     name, a_valid, a_data, b_valid, b_data, ea, eb);
        else passed++;
    endtask

    task automatic test_reset();
        total++;
        if (a_valid !== 1'b0 || a_data !== 32'h0 || b_valid !== 1'b0 || b_data !== 32'h0)
            $display("FAIL reset_initial: a=%b/%h b=%b/%h, want 0/0", a_valid, a_data, b_valid, b_data);
        else passed++;
        write_reg(5'd9, 32'hCAFEF00D, 1, 1);
        a_req = 1; a_addr = 5'd9; b_req = 1; b_addr = 5'd9;
        tick();
        a_req = 0; b_req = 0;
        total++;
        if (a_valid !== 1'b1 || a_data !== 32'hCAFEF00D || b_valid !== 1'b1)
            $display("FAIL reset_prehold: a=%b/%h b_valid=%b, want 1/cafef00d 1", a_valid, a_data, b_valid);
        else passed++;
        #2 clr = 1;
        #1;
        total++;
        if (a_valid !== 1'b0 || a_data !== 32'h0 || b_valid !== 1'b0 || b_data !== 32'h0)
            $display("FAIL reset_async: a=%b/%h b=%b/%h, want 0/0", a_valid, a_data, b_valid, b_data);
        else passed++;
        model_clear();
        tick();
        clr = 0;
        a_req = 1; a_ack = 1; b_req = 1; b_ack = 1;
        for (int i = 0; i < 32; i++) begin
            a_addr = i[4:0]; b_addr = 5'(31 - i);
            tick();
            total++;
            if (a_valid !== 1'b1 || a_data !== 32'h0 || b_valid !== 1'b1 || b_data !== 32'h0)
                $display("FAIL reset_sweep idx %0d: a=%b/%h b=%b/%h, want 1/0", i, a_valid, a_data, b_valid, b_data);
            else passed++;
        end
        a_req = 0; b_req = 0;
        tick();
        a_ack = 0; b_ack = 0;
    endtask

    task automatic test_write_gating();
        write_reg(5'd5, 32'hDEADBEEF, 1, 0);
        read_both("gate_strobe_low", 5'd5, 32'h0, 5'd5, 32'h0);
        write_reg(5'd5, 32'h11111111, 0, 1);
        read_both("gate_ld_low", 5'd5, 32'h0, 5'd5, 32'h0);
        write_reg(5'd5, 32'hDEADBEEF, 1, 1);
        read_both("gate_effective", 5'd5, 32'hDEADBEEF, 5'd5, 32'hDEADBEEF);
    endtask

    task automatic test_zero_reg();
        write_reg(5'd0, 32'hFFFFFFFF, 1, 1);
        read_both("zero_reg", 5'd0, 32'h0, 5'd0, 32'h0);
        // Forwarded write to index 0 must also read as zero.
        ld = 1; strobe = 1; waddr = 0; din = 32'hFFFFFFFF;
        read_both("zero_reg_fwd", 5'd0, 32'h0, 5'd0, 32'h0);
        ld = 0; strobe = 0;
    endtask

    task automatic test_forwarding();
        ld = 1; strobe = 1; waddr = 5'd7; din = 32'h12345678;
        a_req = 1; a_addr = 5'd7; b_req = 1; b_addr = 5'd7;
        tick();
        model[7] = 32'h12345678;
        ld = 0; strobe = 0; a_req = 0; b_req = 0;
        total++;
        if (a_valid !== 1'b1 || a_data !== 32'h12345678)
            $display("FAIL fwd_a: valid=%b data=%h, want 1/12345678", a_valid, a_data);
        else passed++;
        total++;
        if (b_valid !== 1'b1 || b_data !== 32'h12345678)
            $display("FAIL fwd_b: valid=%b data=%h, want 1/12345678", b_valid, b_data);
        else passed++;
        a_ack = 1; b_ack = 1;
        tick();
        a_ack = 0; b_ack = 0;
        read_both("fwd_stored", 5'd7, 32'h12345678, 5'd7, 32'h12345678);
    endtask

    task automatic test_snapshot();
        write_reg(5'd3, 32'hA, 1, 1);
        a_req = 1; a_addr = 5'd3; a_ack = 0;
        tick();
        a_addr = 5'd5;  // new request while held must be ignored
        for (int c = 0; c < 4; c++) begin
            if (c == 0) begin
                ld = 1; strobe = 1; waddr = 5'd3; din = 32'hB;
            end
            #1;
            total++;
            if (a_valid !== 1'b1 || a_data !== 32'hA || a_rdy !== 1'b0)
                $display("FAIL snapshot cycle %0d: valid=%b data=%h rdy=%b, want 1/a/0", c, a_valid, a_data, a_rdy);
            else passed++;
            tick();
            if (c == 0) begin
                model[3] = 32'hB; ld = 0; strobe = 0;
            end
        end
        total++;
        if (a_valid !== 1'b1 || a_data !== 32'hA)
            $display("FAIL snapshot_end: valid=%b data=%h, want 1/a", a_valid, a_data);
        else passed++;
        a_req = 0; a_ack = 1;
        #1;
        total++;
        if (a_rdy !== 1'b1)
            $display("FAIL snapshot_rdy_on_ack: rdy=%b, want 1", a_rdy);
        else passed++;
        tick();
        a_ack = 0;
        read_both("snapshot_after", 5'd3, 32'hB, 5'd3, 32'hB);
    endtask

    task automatic test_back_to_back();
        logic [31:0] v [4];
        for (int i = 1; i <= 3; i++) begin
            v[i] = $urandom;
            write_reg(i[4:0], v[i], 1, 1);
        end
        a_req = 1; a_ack = 1;
        for (int i = 1; i <= 3; i++) begin
            a_addr = i[4:0];
            tick();
            total++;
            if (a_valid !== 1'b1 || a_data !== v[i])
                $display("FAIL b2b reg%0d: valid=%b data=%h, want 1/%h", i, a_valid, a_data, v[i]);
            else passed++;
        end
        a_req = 0;
        tick();
        a_ack = 0;
        total++;
        if (a_valid !== 1'b0 || a_data !== v[3])
            $display("FAIL b2b_drain: valid=%b data=%h, want 0/%h", a_valid, a_data, v[3]);
        else passed++;
    endtask

    task automatic test_random();
        logic        ha = 0, hb = 0, era, erb, fwd;
        logic [31:0] da = '0, db = '0;
        for (int n = 0; n < 400; n++) begin
            ld = ($urandom_range(0, 3) != 0); strobe = ($urandom_range(0, 3) != 0);
            waddr = 5'($urandom_range(0, 7)); din = $urandom;
            a_req = $urandom_range(0, 1); a_addr = 5'($urandom_range(0, 7)); a_ack = $urandom_range(0, 1);
            b_req = $urandom_range(0, 1); b_addr = 5'($urandom_range(0, 7)); b_ack = $urandom_range(0, 1);
            #1;
            era = !ha || a_ack; erb = !hb || b_ack;
            total++;
            if (a_rdy !== era || b_rdy !== erb)
                $display("FAIL rand_rdy %0d: a_rdy=%b b_rdy=%b, want %b %b", n, a_rdy, b_rdy, era, erb);
            else passed++;
            fwd = ld && strobe && waddr != 0;
            if (a_req && era) begin
                ha = 1; da = (a_addr == 0) ? 32'h0 : (fwd && waddr == a_addr) ? din : model[a_addr];
            end else if (ha && a_ack) ha = 0;
            if (b_req && erb) begin
                hb = 1; db = (b_addr == 0) ? 32'h0 : (fwd && waddr == b_addr) ? din : model[b_addr];
            end else if (hb && b_ack) hb = 0;
            if (fwd) model[waddr] = din;
            tick();
            total++;
            if (a_valid !== ha || b_valid !== hb || (ha && a_data !== da) || (hb && b_data !== db))
                $display("FAIL rand_out %0d: a=%b/%h b=%b/%h, want %b/%h %b/%h",
                         n, a_valid, a_data, b_valid, b_data, ha, da, hb, db);
            else passed++;
        end
        ld = 0; strobe = 0; a_req = 0; b_req = 0; a_ack = 1; b_ack = 1;
        tick();
        a_ack = 0; b_ack = 0;
    endtask

    initial begin
        clr = 1; ld = 0; strobe = 0; waddr = 0; din = 0;
        a_req = 0; a_addr = 0; a_ack = 0; b_req = 0; b_addr = 0; b_ack = 0;
        model_clear();
        #1;
        @(negedge clk);
        tick();
        clr = 0;
        test_reset();
        test_write_gating();
        test_zero_reg();
        test_forwarding();
        test_snapshot();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
